// File: rtl/counter_bus_arb_if.sv
// rtl/counter_bus_arb_if.sv - master-side and slave-side signals of the counter bus arbiter
interface counter_bus_arb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic              i_m0_req;
    logic              i_m0_wr;
    logic [ADDR_W-1:0] i_m0_addr;
    logic [DATA_W-1:0] i_m0_wdata;
    logic [DATA_W-1:0] o_m0_rdata;
    logic              o_m0_ack;
    logic              o_m0_err;

    logic              i_m1_req;
    logic              i_m1_wr;
    logic [ADDR_W-1:0] i_m1_addr;
    logic [DATA_W-1:0] i_m1_wdata;
    logic [DATA_W-1:0] o_m1_rdata;
    logic              o_m1_ack;
    logic              o_m1_err;

    logic              o_bus_select;
    logic              o_bus_wr;
    logic [ADDR_W-1:0] o_reg_addr;
    logic [DATA_W-1:0] o_bus_data;
    logic [DATA_W-1:0] i_bus_data;
    logic              i_bus_ack;

    logic              o_busy;
    logic              o_owner;

    // Arbiter side: takes master requests and the peripheral response.
    modport slave (
        input  i_m0_req, i_m0_wr, i_m0_addr, i_m0_wdata,
        output o_m0_rdata, o_m0_ack, o_m0_err,
        input  i_m1_req, i_m1_wr, i_m1_addr, i_m1_wdata,
        output o_m1_rdata, o_m1_ack, o_m1_err,
        output o_bus_select, o_bus_wr, o_reg_addr, o_bus_data,
        input  i_bus_data, i_bus_ack,
        output o_busy, o_owner
    );

    // Environment side: the two bus masters plus the counter peripheral.
    modport master (
        output i_m0_req, i_m0_wr, i_m0_addr, i_m0_wdata,
        input  o_m0_rdata, o_m0_ack, o_m0_err,
        output i_m1_req, i_m1_wr, i_m1_addr, i_m1_wdata,
        input  o_m1_rdata, o_m1_ack, o_m1_err,
        input  o_bus_select, o_bus_wr, o_reg_addr, o_bus_data,
        output i_bus_data, i_bus_ack,
        input  o_busy, o_owner
    );
endinterface

// File: rtl/counter_bus_arb.sv
// rtl/counter_bus_arb.sv - two-master round-robin arbiter for the counter peripheral bus
module counter_bus_arb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst,
    counter_bus_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    // Last XFER cycle index before the transfer is declared hung.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state, state_n;
    logic [TO_W-1:0]   cnt, cnt_n;
    logic              rr, rr_n;          // master that wins the next tie
    logic              owner, owner_n;
    logic              select, select_n;
    logic              wr, wr_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic [DATA_W-1:0] wdata, wdata_n;
    logic [DATA_W-1:0] rdata0, rdata0_n;
    logic [DATA_W-1:0] rdata1, rdata1_n;
    logic              ack0, ack0_n, ack1, ack1_n;
    logic              err0, err0_n, err1, err1_n;
    logic              grant;

    // Next-state and next-output logic: grant in IDLE, wait for ack or timeout in XFER.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rr_n     = rr;
        owner_n  = owner;
        select_n = select;
        wr_n     = wr;
        addr_n   = addr;
        wdata_n  = wdata;
        rdata0_n = rdata0;
        rdata1_n = rdata1;
        ack0_n   = 1'b0;
        ack1_n   = 1'b0;
        err0_n   = 1'b0;
        err1_n   = 1'b0;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_m0_req || bus.i_m1_req) begin
                    grant    = (bus.i_m0_req && bus.i_m1_req) ? rr : bus.i_m1_req;
                    owner_n  = grant;
                    rr_n     = ~grant;
                    select_n = 1'b1;
                    cnt_n    = '0;
                    wr_n     = grant ? bus.i_m1_wr    : bus.i_m0_wr;
                    addr_n   = grant ? bus.i_m1_addr  : bus.i_m0_addr;
                    wdata_n  = grant ? bus.i_m1_wdata : bus.i_m0_wdata;
                    state_n  = XFER;
                end
            end
            XFER: begin
                // An ack in the final counted cycle still completes normally.
                if (bus.i_bus_ack && select) begin
                    select_n = 1'b0;
                    wr_n     = 1'b0;
                    state_n  = RESP;
                    if (owner) begin
                        rdata1_n = bus.i_bus_data;
                        ack1_n   = 1'b1;
                    end else begin
                        rdata0_n = bus.i_bus_data;
                        ack0_n   = 1'b1;
                    end
                end else if (cnt == TO_LAST) begin
                    select_n = 1'b0;
                    wr_n     = 1'b0;
                    state_n  = RESP;
                    if (owner) begin
                        rdata1_n = '0;
                        err1_n   = 1'b1;
                    end else begin
                        rdata0_n = '0;
                        err0_n   = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transfer silently.
    always_ff @(posedge i_sysclk or negedge i_sysrst) begin
        if (!i_sysrst) begin
            state  <= IDLE;
            cnt    <= '0;
            rr     <= 1'b0;
            owner  <= 1'b0;
            select <= 1'b0;
            wr     <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
            rdata0 <= '0;
            rdata1 <= '0;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            err0   <= 1'b0;
            err1   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            rr     <= rr_n;
            owner  <= owner_n;
            select <= select_n;
            wr     <= wr_n;
            addr   <= addr_n;
            wdata  <= wdata_n;
            rdata0 <= rdata0_n;
            rdata1 <= rdata1_n;
            ack0   <= ack0_n;
            ack1   <= ack1_n;
            err0   <= err0_n;
            err1   <= err1_n;
        end
    end

    assign bus.o_bus_select = select;
    assign bus.o_bus_wr     = wr;
    assign bus.o_reg_addr   = addr;
    assign bus.o_bus_data   = wdata;
    assign bus.o_m0_rdata   = rdata0;
    assign bus.o_m1_rdata   = rdata1;
    assign bus.o_m0_ack     = ack0;
    assign bus.o_m1_ack     = ack1;
    assign bus.o_m0_err     = err0;
    assign bus.o_m1_err     = err1;
    assign bus.o_owner      = owner;
    assign bus.o_busy       = (state != IDLE);
endmodule

// File: tb/tb_counter_bus_arb.sv
// tb/tb_counter_bus_arb.sv - self-checking bench for counter_bus_arb
module tb_counter_bus_arb;
    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    counter_bus_arb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

    counter_bus_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT),
        .TO_W   (4)
    ) dut (
        .i_sysclk(clk),
        .i_sysrst(rst_n),
        .bus     (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Master-side request state and the reference model's expectations.
    logic              m_req   [2];
    logic              m_wr    [2];
    logic [ADDR_W-1:0] m_addr  [2];
    logic [DATA_W-1:0] m_wdata [2];
    logic [DATA_W-1:0] exp_rdata [2];
    int                pref;   // master that should win when both request

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive();
        bus_if.i_m0_req   = m_req[0];
        bus_if.i_m0_wr    = m_wr[0];
        bus_if.i_m0_addr  = m_addr[0];
        bus_if.i_m0_wdata = m_wdata[0];
        bus_if.i_m1_req   = m_req[1];
        bus_if.i_m1_wr    = m_wr[1];
        bus_if.i_m1_addr  = m_addr[1];
        bus_if.i_m1_wdata = m_wdata[1];
    endtask

    function automatic logic ack_of(input int m);
        return (m != 0) ? bus_if.o_m1_ack : bus_if.o_m0_ack;
    endfunction

    function automatic logic err_of(input int m);
        return (m != 0) ? bus_if.o_m1_err : bus_if.o_m0_err;
    endfunction

    function automatic logic [DATA_W-1:0] rdata_of(input int m);
        return (m != 0) ? bus_if.o_m1_rdata : bus_if.o_m0_rdata;
    endfunction

    task automatic raise(input int m, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        m_req[m]   = 1'b1;
        m_wr[m]    = wr;
        m_addr[m]  = a;
        m_wdata[m] = d;
    endtask

    task automatic raise_rand(input int m);
        raise(m, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom));
    endtask

    // One complete transaction from an idle arbiter. k = XFER cycle index at which
    // the slave acks (k >= TIMEOUT means never); drop_at = cycle the granted master
    // withdraws its request early (-1 for never).
    task automatic serve(input int k, input logic [DATA_W-1:0] sd, input int drop_at);
        int                g, o, lat, i, exp_sel;
        bit                is_ack;
        logic              e_wr;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        g       = (m_req[0] && m_req[1]) ? pref : (m_req[1] ? 1 : 0);
        o       = 1 - g;
        e_wr    = m_wr[g];
        e_addr  = m_addr[g];
        e_data  = m_wdata[g];
        is_ack  = (k < TIMEOUT);
        exp_sel = is_ack ? k + 1 : TIMEOUT;
        drive();
        lat = 0;
        @(negedge clk);
        lat++;
        chk("select_rise", 32'(bus_if.o_bus_select), 32'd1);
        chk("owner", 32'(bus_if.o_owner), 32'(g));
        i = 0;
        while (bus_if.o_bus_select && i < TIMEOUT + 4) begin
            chk("xfer_wr", 32'(bus_if.o_bus_wr), 32'(e_wr));
            chk("xfer_addr", 32'(bus_if.o_reg_addr), 32'(e_addr));
            chk("xfer_data", 32'(bus_if.o_bus_data), 32'(e_data));
            chk("xfer_no_resp", 32'({ack_of(0), err_of(0), ack_of(1), err_of(1)}), 32'd0);
            chk("xfer_busy", 32'(bus_if.o_busy), 32'd1);
            if (i == drop_at) m_req[g] = 1'b0;
            drive();
            bus_if.i_bus_ack  = (i == k);
            bus_if.i_bus_data = (i == k) ? sd : DATA_W'($urandom);
            @(negedge clk);
            lat++;
            i++;
        end
        bus_if.i_bus_ack = 1'b0;
        exp_rdata[g] = is_ack ? sd : '0;
        chk("select_cycles", 32'(i), 32'(exp_sel));
        chk("resp_latency", 32'(lat), 32'(exp_sel + 1));
        chk("resp_ack", 32'(ack_of(g)), 32'(is_ack));
        chk("resp_err", 32'(err_of(g)), 32'(!is_ack));
        chk("other_quiet", 32'({ack_of(o), err_of(o)}), 32'd0);
        chk("rdata_owner", 32'(rdata_of(g)), 32'(exp_rdata[g]));
        chk("rdata_other_hold", 32'(rdata_of(o)), 32'(exp_rdata[o]));
        chk("resp_select_low", 32'(bus_if.o_bus_select), 32'd0);
        m_req[g] = 1'b0;
        drive();
        pref = o;
        @(negedge clk);
        chk("pulse_end", 32'({ack_of(0), err_of(0), ack_of(1), err_of(1)}), 32'd0);
        chk("idle_busy", 32'(bus_if.o_busy), 32'd0);
        chk("idle_rdata_hold", 32'(rdata_of(g)), 32'(exp_rdata[g]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        drive();
        bus_if.i_bus_ack = 1'b0;
        #1;
        chk("rst_select", 32'(bus_if.o_bus_select), 32'd0);
        chk("rst_busy", 32'(bus_if.o_busy), 32'd0);
        chk("rst_resp", 32'({ack_of(0), err_of(0), ack_of(1), err_of(1)}), 32'd0);
        chk("rst_owner", 32'(bus_if.o_owner), 32'd0);
        chk("rst_wr", 32'(bus_if.o_bus_wr), 32'd0);
        chk("rst_rdata", 32'({rdata_of(0), rdata_of(1)}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pref = 0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        @(negedge clk);
    endtask

    initial begin
        int k;
        int drop;
        for (int m = 0; m < 2; m++) begin
            m_req[m] = 1'b0; m_wr[m] = 1'b0; m_addr[m] = '0; m_wdata[m] = '0;
            exp_rdata[m] = '0;
        end
        pref = 0;
        bus_if.i_bus_ack  = 1'b0;
        bus_if.i_bus_data = '0;
        drive();
        @(negedge clk);
        do_reset();

        // Single master 0 read, slave acks one cycle after select.
        raise(0, 1'b0, 4'h2, 16'h0000);
        serve(1, 16'hBEEF, -1);
        chk("t1_rdata", 32'(bus_if.o_m0_rdata), 32'h0000BEEF);

        // Single master 1 write, immediate ack.
        raise(1, 1'b1, 4'h1, 16'h00FF);
        serve(0, DATA_W'($urandom), -1);
        chk("t2_owner", 32'(bus_if.o_owner), 32'd1);

        // Both masters requesting continuously: grants must alternate.
        for (int n = 0; n < 4; n++) begin
            if (!m_req[0]) raise_rand(0);
            if (!m_req[1]) raise_rand(1);
            serve(int'($urandom_range(0, 3)), DATA_W'($urandom), -1);
        end
        chk("t3_last_owner", 32'(bus_if.o_owner), 32'd1);
        m_req[0] = 1'b0; m_req[1] = 1'b0; drive();

        // Hung slave: timeout error, then a normal transfer is served.
        raise_rand(0);
        serve(TIMEOUT + 5, DATA_W'($urandom), -1);
        raise_rand(1);
        serve(2, DATA_W'($urandom), -1);

        // Ack in the last allowed cycle beats the timeout.
        raise_rand(1);
        serve(TIMEOUT - 1, DATA_W'($urandom), -1);

        // Request dropped mid-transfer: response still delivered.
        raise_rand(0);
        serve(4, DATA_W'($urandom), 1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if (!m_req[0] && $urandom_range(0, 2) != 0) raise_rand(0);
            if (!m_req[1] && $urandom_range(0, 2) != 0) raise_rand(1);
            if (!m_req[0] && !m_req[1]) raise_rand(int'($urandom_range(0, 1)));
            k    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 17))
                                               : int'($urandom_range(0, 3));
            drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1;
            serve(k, DATA_W'($urandom), drop);
        end
        m_req[0] = 1'b0; m_req[1] = 1'b0; drive();

        // Reset during a transfer, then a tie must go to master 0.
        raise_rand(1);
        raise_rand(0);
        drive();
        repeat (3) @(negedge clk);
        chk("pre_rst_select", 32'(bus_if.o_bus_select), 32'd1);
        do_reset();
        raise_rand(0);
        raise_rand(1);
        serve(2, DATA_W'($urandom), -1);
        chk("post_rst_first_owner", 32'(bus_if.o_owner), 32'd0);
        serve(0, DATA_W'($urandom), -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
